// File: rtl/max_detector_if.sv
// Sweep-control, ADC sample and max-tracking result signals of the max detector.
// master drives sweep/ADC inputs; slave is the detector itself.
interface max_detector_if #(
  parameter int unsigned DW = 12
);
  logic          SWEEP_START;
  logic          SWEEP_END;
  logic [DW-1:0] ADC_DATA;
  logic          ADC_VALID;
  logic          CNT_RST;
  logic [DW-1:0] MAX_VAL;
  logic          MAX_VALID;
  logic          BUSY;

  modport master (
    output SWEEP_START, SWEEP_END, ADC_DATA, ADC_VALID,
    input  CNT_RST, MAX_VAL, MAX_VALID, BUSY
  );

  modport slave (
    input  SWEEP_START, SWEEP_END, ADC_DATA, ADC_VALID,
    output CNT_RST, MAX_VAL, MAX_VALID, BUSY
  );
endinterface

// File: rtl/max_detector.sv
// Box-car averages ADC samples during a servo sweep, tracks the running maximum
// block average and pulses CNT_RST on every new maximum and on sweep start.
module max_detector #(
  parameter int unsigned DW       = 12,
  parameter int unsigned AVG_LOG2 = 2,
  parameter int unsigned SETTLE_N = 2,
  parameter int unsigned HYST     = 4
) (
  input  logic           CLK,
  input  logic           RESET,
  max_detector_if.slave  bus
);

  localparam int unsigned AW = DW + AVG_LOG2;
  localparam int unsigned CW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int unsigned SW = (SETTLE_N > 0) ? $clog2(SETTLE_N + 1) : 1;
  localparam logic [CW-1:0] LAST_SMP    = CW'((1 << AVG_LOG2) - 1);
  localparam logic [SW-1:0] LAST_SETTLE = (SETTLE_N > 0) ? SW'(SETTLE_N - 1) : '0;

  typedef enum logic [1:0] {IDLE, SETTLE, TRACK, HOLD} state_t;

  localparam state_t START_STATE = (SETTLE_N > 0) ? SETTLE : TRACK;

  state_t        state, state_n;
  logic [AW-1:0] acc, acc_n;
  logic [CW-1:0] smp_cnt, smp_cnt_n;
  logic [SW-1:0] settle_cnt, settle_cnt_n;
  logic [DW-1:0] max_val, max_val_n;
  logic          max_valid, max_valid_n;
  logic          cnt_rst, cnt_rst_n;
  logic          busy, busy_n;

  logic [AW-1:0] sum;
  logic [DW-1:0] avg;
  logic [DW:0]   thr;
  logic          win;
  logic          block_done;

  // Threshold is one bit wider than MAX_VAL so MAX_VAL+HYST never wraps.
  assign sum        = acc + AW'(bus.ADC_DATA);
  assign avg        = DW'(sum >> AVG_LOG2);
  assign thr        = {1'b0, max_val} + (DW+1)'(HYST);
  assign win        = !max_valid || ({1'b0, avg} > thr);
  assign block_done = bus.ADC_VALID && (smp_cnt == LAST_SMP);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (bus.SWEEP_START) begin
      state_n = START_STATE;
    end else begin
      unique case (state)
        SETTLE: begin
          if (bus.SWEEP_END)
            state_n = HOLD;
          else if (bus.ADC_VALID && settle_cnt == LAST_SETTLE)
            state_n = TRACK;
        end
        TRACK:   if (bus.SWEEP_END) state_n = HOLD;
        default: state_n = state;
      endcase
    end
  end

  always_comb begin
    acc_n        = acc;
    smp_cnt_n    = smp_cnt;
    settle_cnt_n = settle_cnt;
    max_val_n    = max_val;
    max_valid_n  = max_valid;
    cnt_rst_n    = 1'b0;
    busy_n       = (state_n == SETTLE) || (state_n == TRACK);
    if (bus.SWEEP_START) begin
      acc_n        = '0;
      smp_cnt_n    = '0;
      settle_cnt_n = '0;
      max_val_n    = '0;
      max_valid_n  = 1'b0;
      cnt_rst_n    = 1'b1;
    end else begin
      unique case (state)
        SETTLE: begin
          if (bus.ADC_VALID)
            settle_cnt_n = (settle_cnt == LAST_SETTLE) ? '0 : settle_cnt + SW'(1);
          if (bus.SWEEP_END)
            settle_cnt_n = '0;
        end
        TRACK: begin
          if (block_done) begin
            acc_n     = '0;
            smp_cnt_n = '0;
            if (win) begin
              max_val_n   = avg;
              max_valid_n = 1'b1;
              cnt_rst_n   = 1'b1;
            end
          end else if (bus.ADC_VALID) begin
            acc_n     = sum;
            smp_cnt_n = smp_cnt + CW'(1);
          end
          // A block completing on the SWEEP_END cycle is scored above first.
          if (bus.SWEEP_END) begin
            acc_n     = '0;
            smp_cnt_n = '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      acc        <= '0;
      smp_cnt    <= '0;
      settle_cnt <= '0;
      max_val    <= '0;
      max_valid  <= 1'b0;
      cnt_rst    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      acc        <= acc_n;
      smp_cnt    <= smp_cnt_n;
      settle_cnt <= settle_cnt_n;
      max_val    <= max_val_n;
      max_valid  <= max_valid_n;
      cnt_rst    <= cnt_rst_n;
      busy       <= busy_n;
    end
  end

  assign bus.CNT_RST   = cnt_rst;
  assign bus.MAX_VAL   = max_val;
  assign bus.MAX_VALID = max_valid;
  assign bus.BUSY      = busy;

endmodule

// File: tb/tb_max_detector.sv
// Self-checking bench for max_detector: directed sweep scenarios plus random
// sweeps compared cycle by cycle against a sample-queue reference model.
module tb_max_detector;

  localparam int DW       = 12;
  localparam int AVG_LOG2 = 2;
  localparam int SETTLE_N = 2;
  localparam int HYST     = 4;
  localparam int NBLK     = 1 << AVG_LOG2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  max_detector_if #(.DW(DW)) bif ();

  max_detector #(
    .DW       (DW),
    .AVG_LOG2 (AVG_LOG2),
    .SETTLE_N (SETTLE_N),
    .HYST     (HYST)
  ) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bif)
  );

  // Reference model: sweep phase, samples left to drop, pending block samples.
  typedef enum {PH_IDLE, PH_SETTLE, PH_TRACK, PH_HOLD} phase_t;
  phase_t phase;
  int     settle_left;
  int     blk[$];
  int     m_max;
  bit     m_valid;
  bit     m_pulse;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    phase       = PH_IDLE;
    settle_left = 0;
    blk.delete();
    m_max       = 0;
    m_valid     = 1'b0;
    m_pulse     = 1'b0;
  endtask

  task automatic model_step(input bit s, input bit e, input bit v, input int d);
    int total;
    int avg;
    m_pulse = 1'b0;
    if (s) begin
      phase       = (SETTLE_N > 0) ? PH_SETTLE : PH_TRACK;
      settle_left = SETTLE_N;
      blk.delete();
      m_max       = 0;
      m_valid     = 1'b0;
      m_pulse     = 1'b1;
    end else if (phase == PH_SETTLE) begin
      if (v) begin
        settle_left--;
        if (settle_left == 0) phase = PH_TRACK;
      end
      if (e) phase = PH_HOLD;
    end else if (phase == PH_TRACK) begin
      if (v) begin
        blk.push_back(d);
        if (blk.size() == NBLK) begin
          total = 0;
          foreach (blk[k]) total += blk[k];
          avg = total / NBLK;
          if (!m_valid || avg > m_max + HYST) begin
            m_max   = avg;
            m_valid = 1'b1;
            m_pulse = 1'b1;
          end
          blk.delete();
        end
      end
      if (e) begin
        blk.delete();
        phase = PH_HOLD;
      end
    end
  endtask

  task automatic check_outputs(input string ctx);
    check({ctx, ".cnt_rst"},   int'(bif.CNT_RST),   int'(m_pulse));
    check({ctx, ".max_val"},   int'(bif.MAX_VAL),   m_max);
    check({ctx, ".max_valid"}, int'(bif.MAX_VALID), int'(m_valid));
    check({ctx, ".busy"},      int'(bif.BUSY),
          int'(phase == PH_SETTLE || phase == PH_TRACK));
  endtask

  task automatic step(input bit s, input bit e, input bit v, input int d, input string ctx);
    bif.SWEEP_START = s;
    bif.SWEEP_END   = e;
    bif.ADC_VALID   = v;
    bif.ADC_DATA    = DW'(d);
    @(posedge clk);
    model_step(s, e, v, d);
    #1;
    check_outputs(ctx);
  endtask

  task automatic samples(input int d, input int n, input string ctx);
    repeat (n) step(1'b0, 1'b0, 1'b1, d, ctx);
  endtask

  // Reset asserted between edges must clear outputs without waiting for a clock.
  task automatic mid_cycle_reset(input string ctx);
    step(1'b0, 1'b0, 1'b0, 0, ctx);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check({ctx, ".rst_cnt_rst"},   int'(bif.CNT_RST),   0);
    check({ctx, ".rst_max_val"},   int'(bif.MAX_VAL),   0);
    check({ctx, ".rst_max_valid"}, int'(bif.MAX_VALID), 0);
    check({ctx, ".rst_busy"},      int'(bif.BUSY),      0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    bif.SWEEP_START = 1'b0;
    bif.SWEEP_END   = 1'b0;
    bif.ADC_VALID   = 1'b0;
    bif.ADC_DATA    = '0;
    model_reset();
    #12;
    check_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // 1: settling drops the first two samples, first block always scores
    step(1'b1, 1'b0, 1'b0, 0, "t1.start");
    check("t1.start_pulse", int'(bif.CNT_RST), 1);
    samples(900, 2, "t1.settle");
    samples(100, 4, "t1.blk");
    check("t1.max100", int'(bif.MAX_VAL), 100);
    check("t1.pulse", int'(bif.CNT_RST), 1);

    // 2: hysteresis blocks 102, admits 110; lower block leaves max alone
    samples(102, 4, "t2.blk102");
    step(1'b0, 1'b0, 1'b1, 110, "t2.b");
    step(1'b0, 1'b0, 1'b1, 110, "t2.b");
    step(1'b0, 1'b0, 1'b1, 111, "t2.b");
    step(1'b0, 1'b0, 1'b1, 111, "t2.b");
    check("t2.max110", int'(bif.MAX_VAL), 110);
    step(1'b0, 1'b0, 1'b0, 0, "t2.gap");
    check("t2.one_cycle", int'(bif.CNT_RST), 0);
    samples(50, 4, "t2.blk50");

    // 3: near full scale, MAX_VAL+HYST exceeds the sample range
    step(1'b1, 1'b0, 1'b0, 0, "t3.start");
    samples(0, 2, "t3.settle");
    samples(4093, 4, "t3.blk4093");
    samples(4095, 4, "t3.blk4095");
    check("t3.max4093", int'(bif.MAX_VAL), 4093);

    // 4: end mid-block, hold ignores samples, restart clears
    samples(200, 2, "t4.part");
    step(1'b0, 1'b1, 1'b0, 0, "t4.end");
    check("t4.busy", int'(bif.BUSY), 0);
    samples(4000, 8, "t4.hold");
    step(1'b1, 1'b0, 1'b0, 0, "t4.restart");
    check("t4.max_clr", int'(bif.MAX_VAL), 0);

    // 5: start beats end on the same cycle
    samples(300, 3, "t5.pre");
    step(1'b1, 1'b1, 1'b1, 500, "t5.both");
    check("t5.busy", int'(bif.BUSY), 1);
    samples(999, 2, "t5.settle");
    samples(20, 4, "t5.blk");
    check("t5.max20", int'(bif.MAX_VAL), 20);

    // 6: reset mid-block, then samples ignored until a start
    samples(700, 2, "t6.part");
    mid_cycle_reset("t6");
    samples(3000, 8, "t6.idle");
    step(1'b1, 1'b0, 1'b0, 0, "t6.start");

    // Random sweeps: mostly near-peak data so the hysteresis path is exercised
    for (int i = 0; i < 3000; i++) begin
      int  d;
      bit  s, e, v;
      if ($urandom_range(0, 599) == 0) begin
        mid_cycle_reset("rnd");
      end else begin
        s = ($urandom_range(0, 49) == 0);
        e = ($urandom_range(0, 79) == 0);
        v = ($urandom_range(0, 1) == 1);
        d = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4095))
                                        : 3990 + int'($urandom_range(0, 105));
        step(s, e, v, d, "rnd");
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
